// File: rtl/roach_rst_pkg.sv
// rtl/roach_rst_pkg.sv - shared state encoding, counter sizing and saturation limits for the reset sequencer
package roach_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    IDLY_RST  = 3'd1,
    WAIT_RDY  = 3'd2,
    HOLD      = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  localparam int RETRY_MAX_VAL = 15;
  localparam int LOSS_MAX_VAL  = 255;

  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/roach_sync2.sv
// rtl/roach_sync2.sv - two-flop synchroniser with asynchronous active-high reset
module roach_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/roach_reset_sequencer.sv
// rtl/roach_reset_sequencer.sv - DCM lock / IDELAYCTRL calibration reset sequencer in the sys_clk domain
// Define ROACH_RST_AUX_LOCK_EN to also require the synchronised aux_clk_lock.
module roach_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int IDLY_RST_CYCLES    = 8,
  parameter int RDY_TIMEOUT        = 1024,
  parameter int MAX_RETRIES        = 3,
  parameter int HOLD_CYCLES        = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       sys_clk_lock,
  input  logic       aux_clk_lock,
  input  logic       idelay_rdy,
  input  logic       soft_rst_req,
  output logic       idelay_rst,
  output logic       user_rst,
  output logic       sys_ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  import roach_rst_pkg::*;

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, IDLY_RST_CYCLES, RDY_TIMEOUT, HOLD_CYCLES);
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] IDLY_LOAD = CW'(IDLY_RST_CYCLES - 1);
  localparam logic [CW-1:0] RDY_LOAD  = CW'(RDY_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    MAX_RETRY_CNT = 4'(MAX_RETRIES);
  localparam logic [3:0]    RETRY_SAT     = 4'(RETRY_MAX_VAL);
  localparam logic [7:0]    LOSS_SAT      = 8'(LOSS_MAX_VAL);

  logic sys_lock_s;
  logic rdy_s;
  logic lock_s;

  roach_sync2 u_sync_sys_lock (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (sys_clk_lock),
    .q   (sys_lock_s)
  );

  roach_sync2 u_sync_rdy (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (idelay_rdy),
    .q   (rdy_s)
  );

`ifdef ROACH_RST_AUX_LOCK_EN
  logic aux_lock_s;

  roach_sync2 u_sync_aux_lock (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (aux_clk_lock),
    .q   (aux_lock_s)
  );

  assign lock_s = sys_lock_s & aux_lock_s;
`else
  logic unused_aux_clk_lock;

  assign unused_aux_clk_lock = aux_clk_lock;
  assign lock_s = sys_lock_s;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          idelay_rst_q, idelay_rst_d;
  logic          user_rst_q, user_rst_d;
  logic          sys_ready_q, sys_ready_d;
  logic          fault_q, fault_d;
  logic          enter;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    enter   = 1'b0;

    if (state_q == WAIT_LOCK) begin
      if (!lock_s) begin
        cnt_d = LOCK_LOAD;
      end else if (cnt_q == '0) begin
        state_d = IDLY_RST;
        enter   = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (state_q == FAULT) begin
      if (soft_rst_req) begin
        state_d = WAIT_LOCK;
        retry_d = 4'd0;
        enter   = 1'b1;
      end
    end else if (!lock_s) begin
      state_d = WAIT_LOCK;
      retry_d = 4'd0;
      enter   = 1'b1;
      if (loss_q != LOSS_SAT) loss_d = loss_q + 8'd1;
    end else if (soft_rst_req) begin
      // a software request restarts calibration from a clean retry budget
      state_d = IDLY_RST;
      retry_d = 4'd0;
      enter   = 1'b1;
    end else begin
      case (state_q)
        IDLY_RST: begin
          if (cnt_q == '0) begin
            state_d = WAIT_RDY;
            enter   = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        WAIT_RDY: begin
          if (rdy_s) begin
            state_d = HOLD;
            enter   = 1'b1;
          end else if (cnt_q == '0) begin
            if (retry_q != RETRY_SAT) retry_d = retry_q + 4'd1;
            state_d = (retry_d < MAX_RETRY_CNT) ? IDLY_RST : FAULT;
            enter   = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        HOLD: begin
          if (!rdy_s) begin
            state_d = IDLY_RST;
            enter   = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = RUN;
            enter   = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        RUN: begin
          if (!rdy_s) begin
            state_d = IDLY_RST;
            enter   = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    if (enter) begin
      case (state_d)
        WAIT_LOCK: cnt_d = LOCK_LOAD;
        IDLY_RST:  cnt_d = IDLY_LOAD;
        WAIT_RDY:  cnt_d = RDY_LOAD;
        HOLD:      cnt_d = HOLD_LOAD;
        default:   cnt_d = '0;
      endcase
    end

    // outputs follow the next state so they change on the same edge as the state
    idelay_rst_d = (state_d == WAIT_LOCK) || (state_d == IDLY_RST);
    user_rst_d   = (state_d != RUN);
    sys_ready_d  = (state_d == RUN);
    fault_d      = (state_d == FAULT);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      retry_q      <= 4'd0;
      loss_q       <= 8'd0;
      idelay_rst_q <= 1'b1;
      user_rst_q   <= 1'b1;
      sys_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      idelay_rst_q <= idelay_rst_d;
      user_rst_q   <= user_rst_d;
      sys_ready_q  <= sys_ready_d;
      fault_q      <= fault_d;
    end
  end

  assign idelay_rst    = idelay_rst_q;
  assign user_rst      = user_rst_q;
  assign sys_ready     = sys_ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_roach_reset_sequencer.sv
// tb/tb_roach_reset_sequencer.sv - randomized self-checking bench for roach_reset_sequencer
module tb_roach_reset_sequencer;

  localparam int LOCK_STABLE = 16;
  localparam int IDLY        = 8;
  localparam int TMO         = 1024;
  localparam int MAXR        = 3;
  localparam int HOLDC       = 32;
  localparam int SYNC        = 2;
  // synchroniser latency, one decision edge, then the hold window
  localparam int RDY_TO_RUN  = SYNC + 1 + HOLDC;
  localparam int LOSS_TO_RST = SYNC + 1;
  localparam int LOCK_TO_FALL = SYNC + LOCK_STABLE + IDLY;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       sys_clk_lock = 1'b0;
  logic       aux_clk_lock = 1'b1;
  logic       idelay_rdy = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       idelay_rst;
  logic       user_rst;
  logic       sys_ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_delay = 20;
  int low_cnt = 0;
  int exp_loss = 0;

  always #5 sys_clk = ~sys_clk;

  roach_reset_sequencer #(
    .LOCK_STABLE_CYCLES (LOCK_STABLE),
    .IDLY_RST_CYCLES    (IDLY),
    .RDY_TIMEOUT        (TMO),
    .MAX_RETRIES        (MAXR),
    .HOLD_CYCLES        (HOLDC)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .sys_clk_lock  (sys_clk_lock),
    .aux_clk_lock  (aux_clk_lock),
    .idelay_rdy    (idelay_rdy),
    .soft_rst_req  (soft_rst_req),
    .idelay_rst    (idelay_rst),
    .user_rst      (user_rst),
    .sys_ready     (sys_ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // one clock step plus a behavioural IDELAYCTRL: ready rises rdy_delay cycles after its reset falls
  task automatic tick();
    @(posedge sys_clk);
    #1;
    cyc++;
    if (idelay_rst) begin
      low_cnt = 0;
      idelay_rdy = 1'b0;
    end else begin
      if (rdy_delay >= 0 && low_cnt == rdy_delay) idelay_rdy = 1'b1;
      if (low_cnt < 100000) low_cnt++;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return idelay_rst;
      1:       return user_rst;
      2:       return fault;
      default: return sys_ready;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      tick();
      if (sig(which) === val) at = cyc;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    soft_rst_req = 1'b0;
    sys_clk_lock = 1'b1;
    aux_clk_lock = 1'b1;
    idelay_rdy = 1'b0;
    low_cnt = 0;
    tick();
    tick();
    sys_rst = 1'b0;
    cyc = 0;
    exp_loss = 0;
  endtask

  task automatic test_reset();
    logic [15:0] got_v;
    int stuck;
    sys_rst = 1'b1;
    sys_clk_lock = 1'b0;
    tick();
    tick();
    got_v = {idelay_rst, user_rst, sys_ready, fault, retry_cnt, lock_loss_cnt};
    tests++;
    if (got_v !== 16'hC000) begin
      fails++;
      $display("FAIL reset_values: got %h expected %h", got_v, 16'hC000);
    end
    sys_rst = 1'b0;
    cyc = 0;
    stuck = 1;
    repeat (40) begin
      tick();
      if (idelay_rst !== 1'b1 || user_rst !== 1'b1) stuck = 0;
    end
    tests++;
    if (stuck != 1) begin
      fails++;
      $display("FAIL no_lock_holds_reset: got %0d expected 1", stuck);
    end
  endtask

  task automatic test_power_up();
    int at, exp_fall, exp_run;
    logic [6:0] got_v;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      rdy_delay = (i == 0) ? 20 : int'($urandom_range(60, 0));
      exp_fall = LOCK_TO_FALL;
      wait_for(0, 1'b0, 100, at);
      tests++;
      if (at !== exp_fall) begin
        fails++;
        $display("FAIL pwr_idly_fall[%0d]: got %0d expected %0d", i, at, exp_fall);
      end
      exp_run = exp_fall + rdy_delay + RDY_TO_RUN;
      wait_for(1, 1'b0, 200, at);
      tests++;
      if (at !== exp_run) begin
        fails++;
        $display("FAIL pwr_user_fall[%0d]: got %0d expected %0d", i, at, exp_run);
      end
      got_v = {sys_ready, fault, idelay_rst, retry_cnt};
      tests++;
      if (got_v !== 7'b1000000) begin
        fails++;
        $display("FAIL pwr_run_status[%0d]: got %b expected %b", i, got_v, 7'b1000000);
      end
    end
  endtask

  task automatic test_lock_glitch();
    int at, g, l, exp_fall;
    for (int i = 0; i < 4; i++) begin
      g = (i == 0) ? 9 : int'($urandom_range(14, 3));
      l = (i == 0) ? 1 : int'($urandom_range(4, 1));
      do_reset();
      rdy_delay = 20;
      while (cyc < g) tick();
      sys_clk_lock = 1'b0;
      repeat (l) tick();
      sys_clk_lock = 1'b1;
      exp_fall = g + l + LOCK_TO_FALL;
      wait_for(0, 1'b0, 100, at);
      tests++;
      if (at !== exp_fall) begin
        fails++;
        $display("FAIL glitch_idly_fall[%0d]: got %0d expected %0d (g=%0d l=%0d)", i, at, exp_fall, g, l);
      end
    end
  endtask

  task automatic test_timeout();
    int got_rise[$];
    int got_fall[$];
    int exp_rise[$];
    int exp_fall[$];
    int t, fault_at, exp_fault, val, s, at, exp_run;
    logic prev;
    logic [7:0] got_v;
    int stay;
    do_reset();
    rdy_delay = -1;
    prev = 1'b1;
    fault_at = -1;
    for (int n = 0; n < 4000 && fault_at < 0; n++) begin
      tick();
      if (idelay_rst !== prev) begin
        if (idelay_rst) got_rise.push_back(cyc);
        else got_fall.push_back(cyc);
        prev = idelay_rst;
      end
      if (fault === 1'b1) fault_at = cyc;
    end
    t = LOCK_TO_FALL;
    for (int a = 0; a < MAXR; a++) begin
      exp_fall.push_back(t);
      t += TMO;
      if (a < MAXR - 1) begin
        exp_rise.push_back(t);
        t += IDLY;
      end
    end
    exp_fault = t;
    tests++;
    if (got_fall.size() != exp_fall.size() || got_rise.size() != exp_rise.size()) begin
      fails++;
      $display("FAIL tmo_pulse_count: got %0d/%0d expected %0d/%0d", got_rise.size(), got_fall.size(),
               exp_rise.size(), exp_fall.size());
    end
    for (int k = 0; k < exp_fall.size(); k++) begin
      val = (k < got_fall.size()) ? got_fall[k] : -1;
      tests++;
      if (val !== exp_fall[k]) begin
        fails++;
        $display("FAIL tmo_fall[%0d]: got %0d expected %0d", k, val, exp_fall[k]);
      end
    end
    for (int k = 0; k < exp_rise.size(); k++) begin
      val = (k < got_rise.size()) ? got_rise[k] : -1;
      tests++;
      if (val !== exp_rise[k]) begin
        fails++;
        $display("FAIL tmo_rise[%0d]: got %0d expected %0d", k, val, exp_rise[k]);
      end
    end
    tests++;
    if (fault_at !== exp_fault) begin
      fails++;
      $display("FAIL tmo_fault_time: got %0d expected %0d", fault_at, exp_fault);
    end
    got_v = {fault, user_rst, idelay_rst, sys_ready, retry_cnt};
    tests++;
    if (got_v !== {4'b1100, 4'(MAXR)}) begin
      fails++;
      $display("FAIL tmo_fault_status: got %b expected %b", got_v, {4'b1100, 4'(MAXR)});
    end
    stay = 1;
    repeat ($urandom_range(20, 1)) begin
      tick();
      if (fault !== 1'b1) stay = 0;
    end
    tests++;
    if (stay != 1) begin
      fails++;
      $display("FAIL tmo_fault_sticky: got %0d expected 1", stay);
    end
    s = cyc;
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    got_v = {fault, idelay_rst, user_rst, 1'b0, retry_cnt};
    tests++;
    if (got_v !== 8'b01100000) begin
      fails++;
      $display("FAIL tmo_soft_exit: got %b expected %b", got_v, 8'b01100000);
    end
    rdy_delay = int'($urandom_range(40, 0));
    t = s + 1 + LOCK_STABLE + IDLY;
    wait_for(0, 1'b0, 100, at);
    tests++;
    if (at !== t) begin
      fails++;
      $display("FAIL tmo_reseq_fall: got %0d expected %0d", at, t);
    end
    exp_run = t + rdy_delay + RDY_TO_RUN;
    wait_for(1, 1'b0, 200, at);
    tests++;
    if (at !== exp_run) begin
      fails++;
      $display("FAIL tmo_reseq_run: got %0d expected %0d", at, exp_run);
    end
  endtask

  task automatic test_lock_loss_run();
    int at, d, l, rst_at, lo_at, exp_fall, exp_run;
    do_reset();
    rdy_delay = int'($urandom_range(40, 0));
    wait_for(0, 1'b0, 100, at);
    wait_for(1, 1'b0, 200, at);
    tests++;
    if (sys_ready !== 1'b1) begin
      fails++;
      $display("FAIL loss_reach_run: got %b expected 1", sys_ready);
    end
    repeat ($urandom_range(10, 0)) tick();
    d = cyc;
    l = int'($urandom_range(5, 1));
    rdy_delay = int'($urandom_range(40, 0));
    sys_clk_lock = 1'b0;
    rst_at = -1;
    lo_at = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == l) sys_clk_lock = 1'b1;
      if (user_rst === 1'b1 && rst_at < 0) rst_at = cyc;
      if (sys_ready === 1'b0 && lo_at < 0) lo_at = cyc;
    end
    tests++;
    if (rst_at !== d + LOSS_TO_RST || lo_at !== d + LOSS_TO_RST) begin
      fails++;
      $display("FAIL loss_user_rst_time: got %0d/%0d expected %0d", rst_at - d, lo_at - d, LOSS_TO_RST);
    end
    exp_loss++;
    tests++;
    if (int'(lock_loss_cnt) !== exp_loss) begin
      fails++;
      $display("FAIL loss_count: got %0d expected %0d", lock_loss_cnt, exp_loss);
    end
    exp_fall = d + l + LOCK_TO_FALL;
    wait_for(0, 1'b0, 100, at);
    tests++;
    if (at !== exp_fall) begin
      fails++;
      $display("FAIL loss_reseq_fall: got %0d expected %0d", at, exp_fall);
    end
    exp_run = exp_fall + rdy_delay + RDY_TO_RUN;
    wait_for(1, 1'b0, 200, at);
    tests++;
    if (at !== exp_run) begin
      fails++;
      $display("FAIL loss_reseq_run: got %0d expected %0d", at, exp_run);
    end
  endtask

  task automatic test_simultaneous();
    int at, d, exp_fall, exp_run;
    logic [2:0] got_v;
    rdy_delay = int'($urandom_range(40, 0));
    d = cyc;
    sys_clk_lock = 1'b0;
    tick();
    sys_clk_lock = 1'b1;
    tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    got_v = {user_rst, sys_ready, idelay_rst};
    tests++;
    if (got_v !== 3'b101) begin
      fails++;
      $display("FAIL simul_status: got %b expected %b", got_v, 3'b101);
    end
    exp_loss++;
    tests++;
    if (int'(lock_loss_cnt) !== exp_loss) begin
      fails++;
      $display("FAIL simul_loss_count: got %0d expected %0d", lock_loss_cnt, exp_loss);
    end
    exp_fall = d + 1 + LOCK_TO_FALL;
    wait_for(0, 1'b0, 100, at);
    tests++;
    if (at !== exp_fall) begin
      fails++;
      $display("FAIL simul_wait_lock_path: got %0d expected %0d", at, exp_fall);
    end
    exp_run = exp_fall + rdy_delay + RDY_TO_RUN;
    wait_for(1, 1'b0, 200, at);
    tests++;
    if (at !== exp_run) begin
      fails++;
      $display("FAIL simul_reseq_run: got %0d expected %0d", at, exp_run);
    end
  endtask

  task automatic test_soft_run();
    int at, s, exp_fall, exp_run;
    logic [2:0] got_v;
    rdy_delay = int'($urandom_range(40, 0));
    s = cyc;
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    got_v = {user_rst, idelay_rst, sys_ready};
    tests++;
    if (got_v !== 3'b110) begin
      fails++;
      $display("FAIL soft_run_status: got %b expected %b", got_v, 3'b110);
    end
    exp_fall = s + 1 + IDLY;
    wait_for(0, 1'b0, 100, at);
    tests++;
    if (at !== exp_fall) begin
      fails++;
      $display("FAIL soft_run_pulse: got %0d expected %0d", at, exp_fall);
    end
    exp_run = exp_fall + rdy_delay + RDY_TO_RUN;
    wait_for(1, 1'b0, 200, at);
    tests++;
    if (at !== exp_run || int'(lock_loss_cnt) !== exp_loss) begin
      fails++;
      $display("FAIL soft_run_reseq: got %0d loss %0d expected %0d loss %0d", at, lock_loss_cnt, exp_run, exp_loss);
    end
  endtask

  task automatic test_aux_lock();
`ifdef ROACH_RST_AUX_LOCK_EN
    int at, d, l, rst_at, exp_fall, exp_run;
    rdy_delay = int'($urandom_range(40, 0));
    d = cyc;
    l = int'($urandom_range(5, 1));
    aux_clk_lock = 1'b0;
    rst_at = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == l) aux_clk_lock = 1'b1;
      if (user_rst === 1'b1 && rst_at < 0) rst_at = cyc;
    end
    tests++;
    if (rst_at !== d + LOSS_TO_RST) begin
      fails++;
      $display("FAIL aux_loss_time: got %0d expected %0d", rst_at - d, LOSS_TO_RST);
    end
    exp_loss++;
    tests++;
    if (int'(lock_loss_cnt) !== exp_loss) begin
      fails++;
      $display("FAIL aux_loss_count: got %0d expected %0d", lock_loss_cnt, exp_loss);
    end
    exp_fall = d + l + LOCK_TO_FALL;
    wait_for(0, 1'b0, 100, at);
    exp_run = exp_fall + rdy_delay + RDY_TO_RUN;
    wait_for(1, 1'b0, 200, at);
    tests++;
    if (at !== exp_run) begin
      fails++;
      $display("FAIL aux_reseq_run: got %0d expected %0d", at, exp_run);
    end
`else
    int stay;
    aux_clk_lock = 1'b0;
    stay = 1;
    repeat (12) begin
      tick();
      if (sys_ready !== 1'b1 || user_rst !== 1'b0) stay = 0;
    end
    aux_clk_lock = 1'b1;
    tests++;
    if (stay != 1 || int'(lock_loss_cnt) !== exp_loss) begin
      fails++;
      $display("FAIL aux_ignored: got run=%0d loss=%0d expected run=1 loss=%0d", stay, lock_loss_cnt, exp_loss);
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [15:0] got_v;
    #2;
    sys_rst = 1'b1;
    #1;
    got_v = {idelay_rst, user_rst, sys_ready, fault, retry_cnt, lock_loss_cnt};
    tests++;
    if (got_v !== 16'hC000) begin
      fails++;
      $display("FAIL async_reset_values: got %h expected %h", got_v, 16'hC000);
    end
    tick();
    sys_rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_timeout();
    test_lock_loss_run();
    test_simultaneous();
    test_soft_run();
    test_aux_lock();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/roach_reset_sequencer.md
Name: roach_reset_sequencer

Overview:
- Sits directly downstream of the board clock/IDELAYCTRL infrastructure, in the sys_clk domain.
- Consumes the DCM lock indications and the IDELAYCTRL ready flag.
- Drives the IDELAYCTRL reset pulse and the gated user-logic reset.
- Guarantees user logic only leaves reset after the clocks are stable and delay calibration is done. Re-sequences on lock loss, calibration loss or a software request.

Parameters:
- LOCK_STABLE_CYCLES, 16: consecutive cycles the synced lock(s) must be high before sequencing starts.
- IDLY_RST_CYCLES, 8: width of the idelay_rst pulse, in cycles (80 ns at 100 MHz).
- RDY_TIMEOUT, 1024: cycles to wait for idelay_rdy before retrying.
- MAX_RETRIES, 3: failed calibration attempts allowed before FAULT.
- HOLD_CYCLES, 32: cycles user_rst stays asserted after calibration succeeds.

Ports:
- sys_clk  in  1  system clock; all logic in this domain.
- sys_rst  in  1  asynchronous, active-high reset.
- sys_clk_lock  in  1  system DCM lock; asynchronous, synchronised internally.
- aux_clk_lock  in  1  aux DCM lock; asynchronous, synchronised internally. Used only with the optional feature.
- idelay_rdy  in  1  IDELAYCTRL ready; asynchronous, synchronised internally.
- soft_rst_req  in  1  single-cycle software re-sequence request, sys_clk domain.
- idelay_rst  out  1  IDELAYCTRL reset.
- user_rst  out  1  active-high reset for user logic.
- sys_ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  4  calibration retries in the current sequence; saturates at 15.
- lock_loss_cnt  out  8  sticky count of lock-loss events; saturates at 255; cleared only by sys_rst.

Behaviour:
- Reset values: state=WAIT_LOCK, idelay_rst=1, user_rst=1, sys_ready=0, fault=0, all counters=0, synchroniser flops=0.
- Synchronisers: two-flop. lock_s = synced sys_clk_lock (ANDed with synced aux lock when the feature is on). rdy_s = synced idelay_rdy. Input-to-decision latency is 2 cycles.
- Single down-counter cnt, width sized by $clog2 of the largest cycle parameter plus 1. It is reloaded on every state entry.
- WAIT_LOCK:
  - idelay_rst=1, user_rst=1.
  - cnt counts consecutive lock_s=1 cycles; any lock_s=0 restarts the count.
  - After LOCK_STABLE_CYCLES consecutive high cycles, go to IDLY_RST.
  - soft_rst_req is ignored in this state.
- IDLY_RST: idelay_rst=1 for exactly IDLY_RST_CYCLES cycles, then go to WAIT_RDY. idelay_rst drops on entry to WAIT_RDY.
- WAIT_RDY:
  - idelay_rst=0, user_rst=1.
  - rdy_s=1: go to HOLD.
  - After RDY_TIMEOUT cycles without rdy_s: retry_cnt+1, then go to IDLY_RST if the new retry_cnt < MAX_RETRIES, else go to FAULT.
  - rdy_s and timeout on the same cycle: rdy_s wins.
- HOLD:
  - user_rst=1 for HOLD_CYCLES cycles, then go to RUN.
  - rdy_s=0 during HOLD: go to IDLY_RST; retry_cnt is not incremented.
- RUN:
  - user_rst=0, sys_ready=1.
  - rdy_s=0: go to IDLY_RST.
  - soft_rst_req: go to IDLY_RST and clear retry_cnt.
- FAULT:
  - user_rst=1, fault=1, idelay_rst=0.
  - Exits only on soft_rst_req, which goes to WAIT_LOCK and clears retry_cnt, or on sys_rst.
- Global priority in every state except WAIT_LOCK, highest first:
  - lock_s=0: go to WAIT_LOCK and increment lock_loss_cnt (saturating).
  - soft_rst_req.
  - rdy_s / timeout conditions.
- All outputs are registered. user_rst asserts on the cycle after any exit from RUN; it is never combinationally released.
- sys_rst asserted mid-sequence returns the block to reset values immediately (asynchronous). Deassertion is used synchronously.

Optional Feature:
- Macro ROACH_RST_AUX_LOCK_EN.
- Defined: aux_clk_lock gets its own two-flop synchroniser. lock_s = sys_lock_s AND aux_lock_s, so loss of either lock counts as a lock-loss event.
- Undefined: aux_clk_lock is ignored (no synchroniser flops) and lock_s = sys_lock_s.

Decomposition:
- Package roach_rst_pkg contains:
  - state enum: WAIT_LOCK, IDLY_RST, WAIT_RDY, HOLD, RUN, FAULT;
  - the counter-width function;
  - saturation limits RETRY_MAX_VAL=15 and LOSS_MAX_VAL=255.
- One sub-module, roach_sync2: a generic two-flop synchroniser with async active-high reset. It is instantiated 2 or 3 times.

Test Plan:
- Power-up: release sys_rst, sys_clk_lock=1 from cycle 0, idelay_rdy rises 20 cycles after idelay_rst falls. Required:
  - idelay_rst high for exactly 8 cycles after the 16-cycle stable window;
  - user_rst falls exactly 32 cycles after rdy_s is seen;
  - sys_ready=1; retry_cnt=0.
- Lock glitch: drop sys_clk_lock for 1 cycle at the 10th stable cycle. Required: the stable count restarts and idelay_rst is still 1 until 16 consecutive stable cycles are seen.
- Calibration timeout: hold idelay_rdy=0. Required:
  - three 8-cycle idelay_rst pulses spaced by 1024-cycle waits;
  - fault=1 with retry_cnt=3 and user_rst=1;
  - a soft_rst_req pulse then returns the block to WAIT_LOCK with retry_cnt=0.
- Lock loss in RUN: drop sys_clk_lock. Required: user_rst=1 and sys_ready=0 within 4 cycles; lock_loss_cnt=1; full re-sequence on relock.
- Simultaneous events in RUN: lock loss and soft_rst_req on the same synced cycle. Required: state goes to WAIT_LOCK and lock_loss_cnt increments.
- With ROACH_RST_AUX_LOCK_EN: sys lock held 1, aux lock toggled low in RUN. Required: lock-loss behaviour occurs. Without the macro: no effect.
